// File: rtl/sync_ram_pkg.sv
// Shared constants and types for the 128 x 5 single-port scratch RAM.
package sync_ram_pkg;

  localparam int unsigned DATA_W = 5;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage : sync_ram_pkg

// File: rtl/sync_ram.sv
// Single-port synchronous RAM: shared address, separate write/read strobes,
// registered read data that holds until the next read or reset.
module sync_ram
  import sync_ram_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic              read,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out
);

  data_t r_mem [DEPTH];
  data_t r_data_out;

  // Storage, write port and read register; non-blocking updates give
  // read-before-write when both strobes hit the same address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem      <= '{default: '0};
      r_data_out <= '0;
    end else begin
      if (write) begin
        r_mem[address] <= data_in;
      end
      if (read) begin
        r_data_out <= r_mem[address];
      end
    end
  end

  assign data_out = r_data_out;

endmodule : sync_ram

// File: tb/tb_sync_ram.sv
// Self-checking bench for sync_ram: directed plan followed by randomized
// traffic compared against an array-based reference model.
module tb_sync_ram;
  import sync_ram_pkg::*;

  logic  clk;
  logic  reset;
  logic  write;
  logic  read;
  data_t data_in;
  addr_t address;
  data_t data_out;

  // Reference model state.
  data_t model_mem [DEPTH];
  data_t model_dout;

  int unsigned n_cmp;
  int unsigned n_err;

  sync_ram u_dut (
    .clk      (clk),
    .reset    (reset),
    .write    (write),
    .read     (read),
    .data_in  (data_in),
    .address  (address),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input data_t got, input data_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, and compare data_out.
  task automatic step(input logic rst, input logic wr, input logic rd,
                      input data_t din, input addr_t addr, input string tag);
    data_t old_word;
    reset   = rst;
    write   = wr;
    read    = rd;
    data_in = din;
    address = addr;
    @(posedge clk);
    #1;
    if (rst) begin
      foreach (model_mem[i]) model_mem[i] = '0;
      model_dout = '0;
    end else begin
      old_word = model_mem[addr];
      if (rd) model_dout = old_word;
      if (wr) model_mem[addr] = din;
    end
    check_eq(tag, data_out, model_dout);
  endtask

  initial begin
    logic  r_rst, r_wr, r_rd;
    addr_t r_addr;
    data_t r_din;
    n_cmp      = 0;
    n_err      = 0;
    model_dout = '0;
    foreach (model_mem[i]) model_mem[i] = '0;
    reset   = 1'b1;
    write   = 1'b0;
    read    = 1'b0;
    data_in = '0;
    address = '0;

    // Reset for two edges, then read 0x11.
    step(1'b1, 1'b0, 1'b0, 5'd0, 7'h00, "reset0");
    step(1'b1, 1'b0, 1'b0, 5'd0, 7'h00, "reset1");
    step(1'b0, 1'b0, 1'b1, 5'd0, 7'h11, "read_after_reset");
    check_eq("read_after_reset_const", data_out, 5'b00000);

    // Write then read 0x11.
    step(1'b0, 1'b1, 1'b0, 5'b00001, 7'h11, "wr_11");
    step(1'b0, 1'b0, 1'b1, 5'd0, 7'h11, "rd_11");
    check_eq("rd_11_const", data_out, 5'b00001);

    // Write/read 0x33, then hold for four idle cycles.
    step(1'b0, 1'b1, 1'b0, 5'b01000, 7'h33, "wr_33");
    step(1'b0, 1'b0, 1'b1, 5'd0, 7'h33, "rd_33");
    check_eq("rd_33_const", data_out, 5'b01000);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 5'b11111, 7'h11, "hold");
      check_eq("hold_const", data_out, 5'b01000);
    end
    step(1'b0, 1'b0, 1'b1, 5'd0, 7'h11, "reread_11");
    check_eq("reread_11_const", data_out, 5'b00001);

    // Read-before-write at 0x05.
    step(1'b0, 1'b1, 1'b0, 5'b10101, 7'h05, "wr_05");
    step(1'b0, 1'b1, 1'b1, 5'b01010, 7'h05, "rbw_05");
    check_eq("rbw_old_const", data_out, 5'b10101);
    step(1'b0, 1'b0, 1'b1, 5'd0, 7'h05, "rd_05_new");
    check_eq("rbw_new_const", data_out, 5'b01010);

    // Address boundaries.
    step(1'b0, 1'b1, 1'b0, 5'b11111, 7'h00, "wr_00");
    step(1'b0, 1'b1, 1'b0, 5'b10001, 7'h7f, "wr_7f");
    step(1'b0, 1'b0, 1'b1, 5'd0, 7'h00, "rd_00");
    check_eq("rd_00_const", data_out, 5'b11111);
    step(1'b0, 1'b0, 1'b1, 5'd0, 7'h7f, "rd_7f");
    check_eq("rd_7f_const", data_out, 5'b10001);

    // Reset wins over a concurrent write and clears the array.
    step(1'b1, 1'b1, 1'b1, 5'b00111, 7'h7f, "reset_with_write");
    check_eq("reset_with_write_const", data_out, 5'b00000);
    step(1'b0, 1'b0, 1'b1, 5'd0, 7'h7f, "rd_7f_after_reset");
    check_eq("rd_7f_after_reset_const", data_out, 5'b00000);

    // Randomized traffic with occasional resets; small hot address set
    // plus boundaries to make collisions likely.
    for (int i = 0; i < 2000; i++) begin
      r_rst = ($urandom_range(0, 99) == 0);
      r_wr  = 1'(($urandom_range(0, 1)));
      r_rd  = 1'(($urandom_range(0, 1)));
      r_din = data_t'($urandom);
      case ($urandom_range(0, 3))
        0:       r_addr = 7'h00;
        1:       r_addr = 7'h7f;
        2:       r_addr = addr_t'($urandom_range(0, 7));
        default: r_addr = addr_t'($urandom);
      endcase
      step(r_rst, r_wr, r_rd, r_din, r_addr, "random");
    end

    // Fill every word with nonzero data, verify, reset, verify all cleared.
    for (int a = 0; a < int'(DEPTH); a++) begin
      step(1'b0, 1'b1, 1'b0, data_t'($urandom_range(1, 31)), addr_t'(a), "fill");
    end
    for (int a = 0; a < int'(DEPTH); a++) begin
      step(1'b0, 1'b0, 1'b1, 5'd0, addr_t'(a), "fill_read");
    end
    step(1'b1, 1'b0, 1'b0, 5'd0, 7'h00, "final_reset");
    for (int a = 0; a < int'(DEPTH); a++) begin
      step(1'b0, 1'b0, 1'b1, 5'd0, addr_t'(a), "sweep_after_reset");
      check_eq("sweep_zero", data_out, 5'b00000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sync_ram
